// File: rtl/trace_command_issuer.sv
// Trace command issuer: buffers trace records in a small FIFO and replays them
// one at a time as L2 cache requests or as stats-control pulses. It keeps
// saturating per-class handshake counters and a sticky illegal-opcode flag.
module trace_command_issuer #(
  parameter int unsigned addressSize = 32,
  parameter int unsigned commandSize = 8,
  parameter int unsigned indexBits   = 14,
  parameter int unsigned byteSelect  = 6,
  parameter int unsigned fifoDepth   = 4,
  localparam int unsigned tagBits    = addressSize - indexBits - byteSelect
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   traceValid,
  output logic                   traceReady,
  input  logic [commandSize-1:0] traceCommand,
  input  logic [addressSize-1:0] traceAddress,
  output logic                   cacheValid,
  input  logic                   cacheReady,
  output logic [2:0]             cacheOp,
  output logic [tagBits-1:0]     cacheTag,
  output logic [indexBits-1:0]   cacheIndex,
  output logic [byteSelect-1:0]  cacheOffset,
  output logic                   clearStats,
  output logic                   printReq,
  output logic [31:0]            readCount,
  output logic [31:0]            writeCount,
  output logic [31:0]            snoopCount,
  output logic                   badCommand
);

  localparam int unsigned IdxW   = $clog2(fifoDepth);
  localparam int unsigned PtrW   = IdxW + 1;
  localparam int unsigned EntryW = commandSize + addressSize;

  typedef enum logic [1:0] {StIdle, StIssue, StCtrl} state_e;

  state_e                 state_q, state_d;
  logic [EntryW-1:0]      mem_q [fifoDepth];
  logic [EntryW-1:0]      mem_d [fifoDepth];
  logic [PtrW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [2:0]             op_q, op_d;
  logic [tagBits-1:0]     tag_q, tag_d;
  logic [indexBits-1:0]   index_q, index_d;
  logic [byteSelect-1:0]  offset_q, offset_d;
  logic                   is_clear_q, is_clear_d;
  logic                   bad_q, bad_d;
  logic [31:0]            read_count_q, read_count_d;
  logic [31:0]            write_count_q, write_count_d;
  logic [31:0]            snoop_count_q, snoop_count_d;

  logic                   fifo_full, fifo_empty;
  logic                   push, pop, handshake;
  logic [EntryW-1:0]      head;
  logic [commandSize-1:0] head_cmd;
  logic [addressSize-1:0] head_addr;
  logic                   head_is_req, head_is_ctrl;

  // Equal index bits with differing wrap bits means the writer has lapped the reader.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[IdxW] != rd_ptr_q[IdxW]) &&
                      (wr_ptr_q[IdxW-1:0] == rd_ptr_q[IdxW-1:0]);

  assign traceReady = !fifo_full;
  assign push       = traceValid && !fifo_full;
  assign handshake  = cacheValid && cacheReady;

  assign head         = mem_q[rd_ptr_q[IdxW-1:0]];
  assign head_cmd     = head[EntryW-1 -: commandSize];
  assign head_addr    = head[addressSize-1:0];
  assign head_is_req  = (head_cmd <= commandSize'(6));
  assign head_is_ctrl = (head_cmd == commandSize'(8)) || (head_cmd == commandSize'(9));

  assign cacheValid  = (state_q == StIssue);
  assign clearStats  = (state_q == StCtrl) && is_clear_q;
  assign printReq    = (state_q == StCtrl) && !is_clear_q;
  assign cacheOp     = op_q;
  assign cacheTag    = tag_q;
  assign cacheIndex  = index_q;
  assign cacheOffset = offset_q;
  assign readCount   = read_count_q;
  assign writeCount  = write_count_q;
  assign snoopCount  = snoop_count_q;
  assign badCommand  = bad_q;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // FIFO storage and pointer updates.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q[IdxW-1:0]] = {traceCommand, traceAddress};
      wr_ptr_d                  = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
  end

  // Issue FSM: IDLE pops the head and dispatches it by opcode class.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    tag_d      = tag_q;
    index_d    = index_q;
    offset_d   = offset_q;
    is_clear_d = is_clear_q;
    bad_d      = bad_q;
    pop        = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          if (head_is_req) begin
            state_d  = StIssue;
            op_d     = head_cmd[2:0];
            tag_d    = head_addr[addressSize-1 -: tagBits];
            index_d  = head_addr[byteSelect +: indexBits];
            offset_d = head_addr[byteSelect-1:0];
          end else if (head_is_ctrl) begin
            state_d    = StCtrl;
            is_clear_d = (head_cmd == commandSize'(8));
          end else begin
            // Illegal opcode: record is dropped, only the sticky flag remembers it.
            bad_d = 1'b1;
          end
        end
      end
      StIssue: begin
        if (cacheReady) begin
          state_d = StIdle;
        end
      end
      StCtrl: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Handshake counters; a clear cycle never coincides with a handshake.
  always_comb begin
    read_count_d  = read_count_q;
    write_count_d = write_count_q;
    snoop_count_d = snoop_count_q;
    if (clearStats) begin
      read_count_d  = '0;
      write_count_d = '0;
      snoop_count_d = '0;
    end else if (handshake) begin
      case (op_q)
        3'd0, 3'd2:             read_count_d  = sat_inc(read_count_q);
        3'd1:                   write_count_d = sat_inc(write_count_q);
        3'd3, 3'd4, 3'd5, 3'd6: snoop_count_d = sat_inc(snoop_count_q);
        default:                ;
      endcase
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      mem_q         <= '{default: '0};
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      op_q          <= '0;
      tag_q         <= '0;
      index_q       <= '0;
      offset_q      <= '0;
      is_clear_q    <= 1'b0;
      bad_q         <= 1'b0;
      read_count_q  <= '0;
      write_count_q <= '0;
      snoop_count_q <= '0;
    end else begin
      state_q       <= state_d;
      mem_q         <= mem_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      op_q          <= op_d;
      tag_q         <= tag_d;
      index_q       <= index_d;
      offset_q      <= offset_d;
      is_clear_q    <= is_clear_d;
      bad_q         <= bad_d;
      read_count_q  <= read_count_d;
      write_count_q <= write_count_d;
      snoop_count_q <= snoop_count_d;
    end
  end

endmodule

// File: tb/tb_trace_command_issuer.sv
// Bench for trace_command_issuer: directed scenarios plus a random phase, all
// checked against a record-queue model with saturating counters.
module tb_trace_command_issuer;

  logic        clk;
  logic        reset;
  logic        traceValid;
  logic        traceReady;
  logic [7:0]  traceCommand;
  logic [31:0] traceAddress;
  logic        cacheValid;
  logic        cacheReady;
  logic [2:0]  cacheOp;
  logic [11:0] cacheTag;
  logic [13:0] cacheIndex;
  logic [5:0]  cacheOffset;
  logic        clearStats;
  logic        printReq;
  logic [31:0] readCount;
  logic [31:0] writeCount;
  logic [31:0] snoopCount;
  logic        badCommand;

  trace_command_issuer dut (
    .clk          (clk),
    .reset        (reset),
    .traceValid   (traceValid),
    .traceReady   (traceReady),
    .traceCommand (traceCommand),
    .traceAddress (traceAddress),
    .cacheValid   (cacheValid),
    .cacheReady   (cacheReady),
    .cacheOp      (cacheOp),
    .cacheTag     (cacheTag),
    .cacheIndex   (cacheIndex),
    .cacheOffset  (cacheOffset),
    .clearStats   (clearStats),
    .printReq     (printReq),
    .readCount    (readCount),
    .writeCount   (writeCount),
    .snoopCount   (snoopCount),
    .badCommand   (badCommand)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: records in push order, counters, sticky flag.
  logic [39:0] q[$];
  logic [31:0] m_read, m_write, m_snoop;
  bit          m_bad;
  bit          hold;
  logic [2:0]  prev_op;
  logic [11:0] prev_tag;
  logic [13:0] prev_idx;
  logic [5:0]  prev_off;
  bit          last_push, smp_valid;
  int          n_clear, n_print;
  logic [31:0] wc_at_clear;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit legal(input logic [7:0] c);
    return (c <= 8'd6) || (c == 8'd8) || (c == 8'd9);
  endfunction

  function automatic bit legal_pending();
    foreach (q[i]) if (legal(q[i][39:32])) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] sat(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 1;
  endfunction

  // Next legal record in order; illegal ones ahead of it were silently dropped.
  task automatic take(output logic [39:0] rec);
    rec = '0;
    while (q.size() > 0 && !legal(q[0][39:32])) begin
      void'(q.pop_front());
      m_bad = 1'b1;
    end
    check("event_has_record", 32'(q.size() > 0), 1);
    if (q.size() > 0) rec = q.pop_front();
  endtask

  task automatic model_clear();
    q.delete();
    m_read = 0; m_write = 0; m_snoop = 0;
    m_bad = 1'b0; hold = 1'b0;
  endtask

  // Observe one cycle just before its closing edge and advance the model.
  task automatic sample();
    logic [39:0] rec;
    logic [31:0] a;
    last_push = 1'b0;
    smp_valid = cacheValid;
    if (!reset) begin
      check("readCount", readCount, m_read);
      check("writeCount", writeCount, m_write);
      check("snoopCount", snoopCount, m_snoop);
      if (m_bad) check("badCommand_sticky", badCommand, 1);
      check("ctrl_exclusive", 32'(clearStats && printReq), 0);
      if (hold) begin
        check("valid_held", cacheValid, 1);
        check("op_stable", cacheOp, prev_op);
        check("tag_stable", cacheTag, prev_tag);
        check("idx_stable", cacheIndex, prev_idx);
        check("off_stable", cacheOffset, prev_off);
      end
      if (cacheValid && cacheReady) begin
        take(rec);
        a = rec[31:0];
        check("issue_cmd", {29'b0, cacheOp}, {24'b0, rec[39:32]});
        check("issue_tag", cacheTag, a[31:20]);
        check("issue_idx", cacheIndex, a[19:6]);
        check("issue_off", cacheOffset, a[5:0]);
        if (rec[39:32] == 0 || rec[39:32] == 2) m_read = sat(m_read);
        else if (rec[39:32] == 1) m_write = sat(m_write);
        else m_snoop = sat(m_snoop);
      end
      if (clearStats) begin
        take(rec);
        check("clear_cmd", {24'b0, rec[39:32]}, 8);
        wc_at_clear = writeCount;
        n_clear++;
        m_read = 0; m_write = 0; m_snoop = 0;
      end
      if (printReq) begin
        take(rec);
        check("print_cmd", {24'b0, rec[39:32]}, 9);
        n_print++;
      end
      hold     = cacheValid && !cacheReady;
      prev_op  = cacheOp;
      prev_tag = cacheTag;
      prev_idx = cacheIndex;
      prev_off = cacheOffset;
      if (traceValid && traceReady) begin
        q.push_back({traceCommand, traceAddress});
        last_push = 1'b1;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [7:0] c, input logic [31:0] a);
    bit got = 1'b0;
    traceValid = 1'b1; traceCommand = c; traceAddress = a;
    for (int i = 0; i < 60 && !got; i++) begin
      step();
      got = last_push;
    end
    traceValid = 1'b0;
    check("offer_accepted", 32'(got), 1);
  endtask

  task automatic drain();
    int n = 0;
    traceValid = 1'b0;
    cacheReady = 1'b1;
    while (n < 300 && (legal_pending() || cacheValid || clearStats || printReq)) begin
      step();
      n++;
    end
    repeat (8) step();
    check("drain_done", 32'(legal_pending()), 0);
    while (q.size() > 0) begin
      void'(q.pop_front());
      m_bad = 1'b1;
    end
    check("badCommand_drain", badCommand, m_bad);
  endtask

  function automatic logic [7:0] rand_cmd();
    int r = $urandom_range(0, 19);
    if (r < 14) return 8'(r % 7);
    if (r < 16) return 8'd8;
    if (r < 18) return 8'd9;
    if (r == 18) return 8'd7;
    return 8'($urandom_range(10, 255));
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] sum_before, wr_before;
    bit          pushed6;

    reset = 1'b1; traceValid = 1'b0; traceCommand = '0; traceAddress = '0; cacheReady = 1'b1;
    model_clear();
    n_clear = 0; n_print = 0; wc_at_clear = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_traceReady", traceReady, 1);
    check("rst_cacheValid", cacheValid, 0);
    check("rst_ctrl", {30'b0, clearStats, printReq}, 0);
    check("rst_counts", readCount | writeCount | snoopCount, 0);
    check("rst_bad", badCommand, 0);
    check("rst_fields", {3'b0, cacheOp, cacheTag, cacheIndex}, 0);
    check("rst_off", cacheOffset, 0);
    reset = 1'b0;

    // Latency and address split.
    traceValid = 1'b1; traceCommand = 8'd0; traceAddress = 32'h1234_5678;
    step();
    traceValid = 1'b0;
    check("lat_after_push", cacheValid, 0);
    step();
    check("lat_valid", cacheValid, 1);
    check("lat_op", cacheOp, 0);
    check("lat_tag", cacheTag, 12'h123);
    check("lat_idx", cacheIndex, 14'h1159);
    check("lat_off", cacheOffset, 6'h38);
    step();
    check("lat_readCount", readCount, 1);
    check("lat_back_idle", cacheValid, 0);

    // Stall: output register plus four FIFO slots, then 1-in-2 drain rate.
    sum_before = m_read + m_write + m_snoop;
    cacheReady = 1'b0;
    for (int i = 0; i < 5; i++) begin
      offer(8'($urandom_range(0, 6)), $urandom);
      check("ready_during_fill", traceReady, (i < 4) ? 1 : 0);
    end
    traceValid = 1'b1; traceCommand = 8'($urandom_range(0, 6)); traceAddress = $urandom;
    for (int i = 0; i < 3; i++) begin
      step();
      check("held_off_when_full", 32'(last_push), 0);
    end
    cacheReady = 1'b1;
    pushed6 = 1'b0;
    for (int k = 0; k < 12; k++) begin
      step();
      check("rate_pattern", 32'(smp_valid), (k % 2 == 0) ? 1 : 0);
      if (last_push) begin
        traceValid = 1'b0;
        pushed6 = 1'b1;
      end
    end
    check("sixth_accepted", 32'(pushed6), 1);
    drain();
    check("stall_sum", readCount + writeCount + snoopCount - sum_before, 6);

    // Write, clear, print.
    wr_before = m_write;
    n_clear = 0; n_print = 0;
    offer(8'd1, 32'hCAFE_0040);
    offer(8'd8, 32'h0);
    offer(8'd9, 32'h0);
    drain();
    check("clear_pulses", n_clear, 1);
    check("print_pulses", n_print, 1);
    check("write_before_clear", wc_at_clear, wr_before + 1);
    check("write_after_clear", writeCount, 0);

    // Illegal opcode then snoop.
    offer(8'd7, 32'h1111_1111);
    offer(8'd4, 32'hABCD_EF01);
    drain();
    check("bad_set", badCommand, 1);
    check("snoop_one", snoopCount, 1);
    repeat (5) step();
    check("bad_sticky", badCommand, 1);

    // Reset in the middle of a stalled request.
    cacheReady = 1'b0;
    offer(8'd2, 32'h5555_AAAA);
    for (int i = 0; i < 10 && !cacheValid; i++) step();
    check("pre_reset_valid", cacheValid, 1);
    reset = 1'b1;
    #1;
    check("reset_drops_valid", cacheValid, 0);
    check("reset_ready", traceReady, 1);
    check("reset_counts", readCount | writeCount | snoopCount, 0);
    check("reset_bad", badCommand, 0);
    model_clear();
    cacheReady = 1'b1;
    #1;
    reset = 1'b0;
    traceValid = 1'b1; traceCommand = 8'd1; traceAddress = 32'h0F0F_F0F0;
    step();
    traceValid = 1'b0;
    check("first_edge_accept", 32'(last_push), 1);
    step();
    check("post_reset_issue", cacheValid, 1);
    drain();
    check("post_reset_write", writeCount, 1);
    check("no_stale_read", readCount, 0);

    // Saturation.
    force dut.read_count_q = 32'hFFFF_FFFF;
    m_read = 32'hFFFF_FFFF;
    step();
    release dut.read_count_q;
    offer(8'd0, 32'h0000_1000);
    drain();
    check("read_saturated", readCount, 32'hFFFF_FFFF);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      traceValid   = ($urandom_range(0, 9) < 7);
      traceCommand = rand_cmd();
      traceAddress = $urandom;
      cacheReady   = ($urandom_range(0, 1) == 1);
      step();
    end
    drain();
    check("final_read", readCount, m_read);
    check("final_write", writeCount, m_write);
    check("final_snoop", snoopCount, m_snoop);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
